// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate test sequencer.
package gate_test_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int unsigned NUM_VECTORS = 4;

    // Expected truth tables, indexed by {b,a}
    localparam logic [3:0] TRUTH_AND = 4'b1000;
    localparam logic [3:0] TRUTH_OR  = 4'b1110;
    localparam logic [3:0] TRUTH_XOR = 4'b0110;

endpackage

// File: rtl/gate_settle_timer.sv
// Loadable down-counter timing the settle window after a vector is applied.
module gate_settle_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Load on request, otherwise count down while enabled, stopping at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    // Expired marks the final settle cycle (count at 1 or already drained)
    always_comb begin
        expired = (count <= WIDTH'(1));
    end

endmodule

// File: rtl/gate_test_sequencer.sv
// Applies the four input vectors to a 2-input gate, samples its output and
// records mismatches against the expected truth table.
module gate_test_sequencer
    import gate_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [3:0]  TRUTH         = TRUTH_AND
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_s,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    state_t     state;
    logic [1:0] vec;
    logic [1:0] vec_inc;
    logic       mismatch;
    logic [2:0] err_nxt;
    logic [3:0] fail_nxt;
    logic       timer_load;
    logic       timer_en;
    logic       settle_expired;

    // Timer is loaded on the APPLY cycle and runs through SETTLE
    always_comb begin
        timer_load = (state == ST_APPLY) && !abort;
        timer_en   = (state == ST_SETTLE);
    end

    gate_settle_timer #(
        .WIDTH (4)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (4'(SETTLE_CYCLES)),
        .en       (timer_en),
        .expired  (settle_expired)
    );

    // Result updates for the vector currently being sampled
    always_comb begin
        vec_inc  = vec + 2'd1;
        mismatch = (dut_s != TRUTH[vec]);
        err_nxt  = err_count + {2'b00, mismatch};
        fail_nxt = fail_vec;
        if (mismatch) begin
            fail_nxt[vec] = 1'b1;
        end
    end

    // Sequencer FSM with registered outputs; abort overrides any busy-state
    // transition, and a/b are loaded on entry to APPLY so they are valid for
    // the whole vector window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            vec       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_APPLY;
                        vec       <= '0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_vec  <= '0;
                    end
                end
                ST_APPLY, ST_SETTLE, ST_SAMPLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (state == ST_APPLY) begin
                        state <= ST_SETTLE;
                    end else if (state == ST_SETTLE) begin
                        if (settle_expired) begin
                            state <= ST_SAMPLE;
                        end
                    end else begin
                        err_count <= err_nxt;
                        fail_vec  <= fail_nxt;
                        if (vec == 2'(NUM_VECTORS - 1)) begin
                            state <= ST_DONE;
                            a     <= 1'b0;
                            b     <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt == '0);
                        end else begin
                            state <= ST_APPLY;
                            vec   <= vec_inc;
                            a     <= vec_inc[0];
                            b     <= vec_inc[1];
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    a     <= 1'b0;
                    b     <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Self-checking bench: two sequencers (AND/settle 1, XOR/settle 3) each test
// a modelled gate; expectations come from a cycle-indexed behavioural model.
module tb_gate_test_sequencer;
    import gate_test_pkg::*;

    localparam int unsigned S1 = 1;
    localparam int unsigned S2 = 3;
    localparam logic [3:0]  T1 = TRUTH_AND;
    localparam logic [3:0]  T2 = TRUTH_XOR;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [3:0] tbl1, tbl2;
    logic       dut_s1, dut_s2;
    logic       a1, b1, busy1, done1, pass1;
    logic       a2, b2, busy2, done2, pass2;
    logic [2:0] ec1, ec2;
    logic [3:0] fv1, fv2;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    // Gates under test, looked up from the model's truth tables
    assign dut_s1 = tbl1[{b1, a1}];
    assign dut_s2 = tbl2[{b2, a2}];

    gate_test_sequencer #(.SETTLE_CYCLES(S1), .TRUTH(T1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_s(dut_s1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(ec1), .fail_vec(fv1)
    );

    gate_test_sequencer #(.SETTLE_CYCLES(S2), .TRUTH(T2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_s(dut_s2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(ec2), .fail_vec(fv2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Gate behaviour: 0 AND, 1 stuck-0, 2 stuck-1, 3 NAND, 4 OR, 5 XOR, else random table
    function automatic logic [3:0] gate_table(input int mode, input logic [3:0] rnd);
        logic [3:0] t;
        logic ga, gb;
        t = '0;
        for (int v = 0; v < 4; v++) begin
            ga = v[0];
            gb = v[1];
            case (mode)
                0: t[v] = ga & gb;
                1: t[v] = 1'b0;
                2: t[v] = 1'b1;
                3: t[v] = ~(ga & gb);
                4: t[v] = ga | gb;
                5: t[v] = ga ^ gb;
                default: t[v] = rnd[v];
            endcase
        end
        return t;
    endfunction

    function automatic int popcount(input logic [3:0] x);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(x[i]);
        return n;
    endfunction

    // Mismatches recorded by k cycles after the accept edge: vector w has
    // been sampled once per*(w+1) <= k.
    function automatic logic [3:0] partial(input logic [3:0] diff, input int k, input int per);
        logic [3:0] m = '0;
        for (int w = 0; w < 4; w++) m[w] = (per * (w + 1) <= k);
        return diff & m;
    endfunction

    task automatic chk_unit(input string u, input logic ao, bo, bzo, dno, pso,
                            input logic [2:0] eco, input logic [3:0] fvo,
                            input logic ea, eb, ebz, edn, eps,
                            input logic [3:0] efv);
        chk({u, "_a"}, ao, ea);
        chk({u, "_b"}, bo, eb);
        chk({u, "_busy"}, bzo, ebz);
        chk({u, "_done"}, dno, edn);
        chk({u, "_pass"}, pso, eps);
        chk({u, "_err_count"}, eco, popcount(efv));
        chk({u, "_fail_vec"}, fvo, efv);
    endtask

    // Expected outputs k cycles after the accept edge of a run
    task automatic chk_cyc1(input int k, input logic [3:0] diff);
        int per = 2 + S1;
        int v = k / per;
        if (k < 4 * per)
            chk_unit($sformatf("u1_k%0d", k), a1, b1, busy1, done1, pass1, ec1, fv1,
                     v[0], v[1], 1'b1, 1'b0, 1'b0, partial(diff, k, per));
        else
            chk_unit($sformatf("u1_k%0d", k), a1, b1, busy1, done1, pass1, ec1, fv1,
                     1'b0, 1'b0, 1'b0, 1'b1, diff == '0, diff);
    endtask

    task automatic chk_cyc2(input int k, input logic [3:0] diff);
        int per = 2 + S2;
        int v = k / per;
        if (k < 4 * per)
            chk_unit($sformatf("u2_k%0d", k), a2, b2, busy2, done2, pass2, ec2, fv2,
                     v[0], v[1], 1'b1, 1'b0, 1'b0, partial(diff, k, per));
        else
            chk_unit($sformatf("u2_k%0d", k), a2, b2, busy2, done2, pass2, ec2, fv2,
                     1'b0, 1'b0, 1'b0, 1'b1, diff == '0, diff);
    endtask

    task automatic chk_reset(input string tag);
        chk_unit({tag, "_u1"}, a1, b1, busy1, done1, pass1, ec1, fv1,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        chk_unit({tag, "_u2"}, a2, b2, busy2, done2, pass2, ec2, fv2,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    // One run; hold keeps start high, abort_at >= 0 aborts at that cycle,
    // with_abort raises abort together with start.
    task automatic do_run(input int m1, m2, input logic [3:0] r1, r2,
                          input bit hold, input int abort_at, input bit with_abort);
        logic [3:0] d1, d2;
        tbl1 = gate_table(m1, r1);
        tbl2 = gate_table(m2, r2);
        d1 = tbl1 ^ T1;
        d2 = tbl2 ^ T2;
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(posedge clk);
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 0) abort = 1'b0;
            if (!hold) start = 1'b0;
            if (abort_at >= 0 && k == abort_at + 1) begin
                abort = 1'b0;
                chk_unit("abort_u1", a1, b1, busy1, done1, pass1, ec1, fv1,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, partial(d1, abort_at, 2 + S1));
                chk_unit("abort_u2", a2, b2, busy2, done2, pass2, ec2, fv2,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, partial(d2, abort_at, 2 + S2));
                repeat (3) @(negedge clk);
                chk("abort_idle_busy1", busy1, 1'b0);
                chk("abort_idle_done1", done1, 1'b0);
                chk("abort_idle_busy2", busy2, 1'b0);
                break;
            end
            chk_cyc1(k, d1);
            chk_cyc2(k, d2);
            if (k == abort_at) begin
                abort = 1'b1;
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tbl1 = gate_table(0, 4'h0);
        tbl2 = gate_table(5, 4'h0);
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy1", busy1, 1'b0);

        // Correct gates: both pass
        do_run(0, 5, 4'h0, 4'h0, 1'b0, -1, 1'b0);

        // Abort in DONE does nothing
        @(negedge clk);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        chk("done_abort_done1", done1, 1'b1);
        chk("done_abort_pass1", pass1, 1'b1);
        chk("done_abort_busy1", busy1, 1'b0);
        chk("done_abort_done2", done2, 1'b1);
        abort = 1'b0;

        // Stuck-at-0, started from DONE with abort also high
        do_run(1, 1, 4'h0, 4'h0, 1'b0, -1, 1'b1);
        // Stuck-at-1 and NAND
        do_run(2, 2, 4'h0, 4'h0, 1'b0, -1, 1'b0);
        do_run(3, 3, 4'h0, 4'h0, 1'b0, -1, 1'b0);
        do_run(4, 0, 4'h0, 4'h0, 1'b0, -1, 1'b0);

        // Random faulty gates
        for (int i = 0; i < 4; i++)
            do_run(6, 6, 4'($urandom), 4'($urandom), 1'b0, -1, 1'b0);

        // start held through the run, abort during the third vector
        do_run(2, 2, 4'h0, 4'h0, 1'b1, 7, 1'b0);

        // Reset asserted mid-SETTLE of vector 2
        tbl1 = gate_table(2, 4'h0);
        tbl2 = gate_table(2, 4'h0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1 chk_reset("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_busy1", busy1, 1'b0);
        chk("post_reset_busy2", busy2, 1'b0);
        do_run(0, 5, 4'h0, 4'h0, 1'b0, -1, 1'b0);
        do_run(3, 4, 4'h0, 4'h0, 1'b0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
